// File: rtl/pc_sequencer.sv
// pc_sequencer: launches a resident program and steers the PC's
// init/halt/branch/target inputs, reporting run statistics.
module pc_sequencer #(
  parameter logic [9:0] PROG0_START = 10'd0,
  parameter logic [9:0] PROG0_END   = 10'd63,
  parameter logic [9:0] PROG1_START = 10'd64,
  parameter logic [9:0] PROG1_END   = 10'd255,
  parameter logic [9:0] PROG2_START = 10'd256,
  parameter logic [9:0] PROG2_END   = 10'd511
) (
  input  logic        CLK,
  input  logic        Init_n,
  input  logic        Start,
  input  logic [1:0]  Prog_sel,
  input  logic        Abort,
  input  logic [9:0]  PC,
  input  logic        Jump,
  input  logic        Branch_z,
  input  logic        ALU_zero,
  input  logic [9:0]  Jump_target,
  input  logic        Stall,
  output logic        PC_init,
  output logic        PC_halt,
  output logic        PC_branch,
  output logic [15:0] PC_target,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [15:0] Cycle_count,
  output logic [15:0] Stall_count
);

  typedef enum logic [2:0] {
    S_RST,
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  sel_reg;
  logic [15:0] cyc_q;
  logic [15:0] stl_q;
  logic        err_q;
  logic        stall_inc;
  logic [9:0]  tgt;
  logic [9:0]  start_addr;
  logic [9:0]  end_addr;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  always_comb begin
    start_addr = PROG0_START;
    end_addr   = PROG0_END;
    unique case (sel_reg)
      2'd1: begin
        start_addr = PROG1_START;
        end_addr   = PROG1_END;
      end
      2'd2: begin
        start_addr = PROG2_START;
        end_addr   = PROG2_END;
      end
      default: ;
    endcase
  end

  logic idle_like;
  logic sel_bad;
  logic launch_ok;
  logic taken;
  logic at_end;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign sel_bad   = (Prog_sel == 2'd3);
  assign launch_ok = idle_like && Start && !sel_bad;
  assign taken     = Jump || (Branch_z && ALU_zero);
  assign at_end    = (PC == end_addr);

  // Mutually exclusive RUN decode, highest priority first
  logic run_abort;
  logic run_stall;
  logic run_jump;
  logic run_end;

  assign run_abort = Abort;
  assign run_stall = !Abort && Stall;
  assign run_jump  = !Abort && !Stall && taken;
  assign run_end   = !Abort && !Stall && !taken && at_end;

  always_comb begin
    state_nxt = state;
    PC_init   = 1'b0;
    PC_halt   = 1'b0;
    PC_branch = 1'b0;
    tgt       = 10'd0;
    stall_inc = 1'b0;
    unique case (state)
      S_RST: begin
        PC_init   = 1'b1;
        PC_halt   = 1'b1;
        state_nxt = S_IDLE;
      end
      S_IDLE, S_DONE: begin
        PC_halt = 1'b1;
        if (launch_ok) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        PC_branch = 1'b1;
        tgt       = start_addr;
        state_nxt = Abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        unique case (1'b1)
          run_abort: begin
            PC_halt   = 1'b1;
            state_nxt = S_IDLE;
          end
          run_stall: begin
            PC_halt   = 1'b1;
            stall_inc = 1'b1;
          end
          run_jump: begin
            PC_branch = 1'b1;
            tgt       = Jump_target;
          end
          run_end: begin
            PC_halt   = 1'b1;
            state_nxt = S_DONE;
          end
          default: ;
        endcase
      end
      default: state_nxt = S_RST;
    endcase
  end

  assign PC_target   = {6'b0, tgt};
  assign Busy        = (state == S_LAUNCH) || (state == S_RUN);
  assign Done        = (state == S_DONE);
  assign Err         = err_q;
  assign Cycle_count = cyc_q;
  assign Stall_count = stl_q;

  always_ff @(posedge CLK or negedge Init_n) begin
    if (!Init_n) begin
      state   <= S_RST;
      sel_reg <= 2'd0;
      cyc_q   <= 16'd0;
      stl_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= idle_like && Start && sel_bad;
      if (launch_ok) begin
        sel_reg <= Prog_sel;
        cyc_q   <= 16'd0;
        stl_q   <= 16'd0;
      end else if (Busy) begin
        cyc_q <= sat_inc(cyc_q);
        if (stall_inc) stl_q <= sat_inc(stl_q);
      end
    end
  end

endmodule
